// File: rtl/ascii_hex_parser.sv
// ascii_hex_parser: accumulates ASCII hex digits into a binary value and
// presents the token on a valid/ready output when a terminator arrives.
// Illegal characters and over-long tokens raise a one-cycle error pulse
// and the rest of the token is discarded up to the next terminator.
module ascii_hex_parser #(
    parameter int NDIGITS = 4,
    parameter int CW      = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [7:0]           in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [4*NDIGITS-1:0] out_value,
    output logic [CW-1:0]        out_digits,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 err,
    output logic [1:0]           err_code
);

    localparam int VW = 4 * NDIGITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCUM,
        S_DISCARD
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_OVERFLOW = 2'b10;

    state_t         state_q, state_d;
    logic [VW-1:0]  acc_q, acc_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic [VW-1:0]  out_value_q, out_value_d;
    logic [CW-1:0]  out_digits_q, out_digits_d;
    logic           out_valid_q, out_valid_d;
    logic           err_q, err_d;
    logic [1:0]     err_code_q, err_code_d;

    logic           accept;
    logic           is_digit;
    logic           is_term;
    logic [3:0]     nibble;

    // Input is taken only while no parsed value is waiting; out_ready has no
    // combinational path to in_ready.
    assign in_ready = ~out_valid_q;
    assign accept   = in_valid & in_ready;

    // Classify the incoming character and derive its nibble value.
    always_comb begin
        // NOTE: every combinational output gets a default first so that no
        // path through the block leaves it unassigned (which would infer a latch).
        is_digit = 1'b0;
        is_term  = 1'b0;
        nibble   = in_data[3:0];
        if (in_data >= 8'h30 && in_data <= 8'h39) begin
            is_digit = 1'b1;
        end else if ((in_data >= 8'h61 && in_data <= 8'h66) ||
                     (in_data >= 8'h41 && in_data <= 8'h46)) begin
            // 'a'..'f' and 'A'..'F' both carry 1..6 in the low nibble.
            is_digit = 1'b1;
            nibble   = in_data[3:0] + 4'd9;
        end else if (in_data == 8'h0D || in_data == 8'h0A || in_data == 8'h20) begin
            is_term = 1'b1;
        end
    end

    // Next-state logic for the token FSM, accumulator and output registers.
    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        out_value_d  = out_value_q;
        out_digits_d = out_digits_q;
        out_valid_d  = out_valid_q & ~out_ready;
        err_d        = 1'b0;
        err_code_d   = ERR_NONE;

        // A load can only happen when out_valid_q is low, so it never
        // collides with the handshake clear above.
        if (accept) begin
            unique case (state_q)
                S_IDLE: begin
                    if (is_digit) begin
                        acc_d   = {{(VW-4){1'b0}}, nibble};
                        cnt_d   = CW'(1);
                        state_d = S_ACCUM;
                    end else if (!is_term) begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                        state_d    = S_DISCARD;
                    end
                end
                S_ACCUM: begin
                    if (is_digit) begin
                        if (cnt_q == CW'(NDIGITS)) begin
                            err_d      = 1'b1;
                            err_code_d = ERR_OVERFLOW;
                            state_d    = S_DISCARD;
                        end else begin
                            acc_d = {acc_q[VW-5:0], nibble};
                            cnt_d = cnt_q + CW'(1);
                        end
                    end else if (is_term) begin
                        out_value_d  = acc_q;
                        out_digits_d = cnt_q;
                        out_valid_d  = 1'b1;
                        acc_d        = '0;
                        cnt_d        = '0;
                        state_d      = S_IDLE;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = ERR_ILLEGAL;
                        state_d    = S_DISCARD;
                    end
                end
                S_DISCARD: begin
                    if (is_term) begin
                        acc_d   = '0;
                        cnt_d   = '0;
                        state_d = S_IDLE;
                    end
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    // State registers with synchronous reset; a reset mid-token drops it silently.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values regardless of statement order.
        if (rst) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            out_value_q  <= '0;
            out_digits_q <= '0;
            out_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            out_value_q  <= out_value_d;
            out_digits_q <= out_digits_d;
            out_valid_q  <= out_valid_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
        end
    end

    assign out_value  = out_value_q;
    assign out_digits = out_digits_q;
    assign out_valid  = out_valid_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

endmodule
